// File: rtl/cnn_pkg.sv
// cnn_pkg: shared types and arithmetic helpers for the dense layer datapath.
package cnn_pkg;
   typedef enum logic [2:0] {IDLE, LOAD, FEED, DRAIN, EMIT, FINISH} dense_state_t;
   function automatic int acc_width(input int dw, input int n);
      return 2 * dw + $clog2(n) + 2;
   endfunction
   // Arithmetic shift by sh with optional round-half-up, then clamp to a signed dw-bit range.
   function automatic logic signed [63:0] sat_round(input logic signed [63:0] acc, input int sh,
                                                    input bit rnd, input int dw);
      logic signed [63:0] r, hi;
      r = (rnd && sh > 0) ? (acc + (64'sd1 <<< (sh - 1))) >>> sh : acc >>> sh;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      return r > hi ? hi : r < -hi - 64'sd1 ? -hi - 64'sd1 : r;
   endfunction
endpackage

// File: rtl/dense_lane_mac.sv
// dense_lane_mac: one neuron lane - bias preload, multiply-accumulate, scale/round/saturate.
// DENSE_RELU_EN defined: negative saturated results are clamped to zero.
module dense_lane_mac import cnn_pkg::*; #(
   parameter int DW    = 16,
   parameter int FRAC  = 7,
   parameter int ACCW  = 36,
   parameter int SH    = 7,
   parameter int ROUND = 1
)(
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_i,
   input  logic                 mac_i,
   input  logic signed [DW-1:0] bias_i,
   input  logic signed [DW-1:0] x_i,
   input  logic signed [DW-1:0] w_i,
   output logic signed [DW-1:0] y_o
);
   logic signed [ACCW-1:0] acc_q, acc_d;
   logic signed [2*DW-1:0] prod;
   logic signed [DW-1:0]   sat_v;
   always_comb begin
      prod  = x_i * w_i;
      acc_d = load_i ? ACCW'(bias_i) <<< FRAC : mac_i ? acc_q + ACCW'(prod) : acc_q;
      sat_v = DW'(sat_round(64'(acc_q), SH, ROUND != 0, DW));
   end
   always_ff @(posedge clk)
      acc_q <= reset ? '0 : acc_d;
`ifdef DENSE_RELU_EN
   assign y_o = sat_v[DW-1] ? '0 : sat_v;
`else
   assign y_o = sat_v;
`endif
endmodule

// File: rtl/dense_lanes.sv
// dense_lanes: LANES-wide fully-connected layer streaming results over valid/ready.
// Weight/bias ROMs are packed parameters (entry k at bits [k*DATA_WIDTH +: DATA_WIDTH]); DENSE_RELU_EN enables fused ReLU.
module dense_lanes import cnn_pkg::*; #(
   parameter int DATA_WIDTH = 16,
   parameter int FRAC_BITS  = 7,
   parameter int IN_DIM     = 1568,
   parameter int OUT_DIM    = 10,
   parameter int LANES      = 4,
   parameter int LAT        = 1,
   parameter int POST_SHIFT = 0,
   parameter int ROUND      = 1,
   parameter logic [OUT_DIM*IN_DIM*DATA_WIDTH-1:0] WEIGHTS = '0,
   parameter logic [OUT_DIM*DATA_WIDTH-1:0]        BIASES  = '0,
   localparam int AW = IN_DIM > 1 ? $clog2(IN_DIM) : 1,
   localparam int OW = OUT_DIM > 1 ? $clog2(OUT_DIM) : 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   output logic                  busy,
   output logic [AW-1:0]         in_addr,
   output logic                  in_en,
   input  logic [DATA_WIDTH-1:0] in_q,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [OW-1:0]         out_idx,
   output logic                  done
);
   localparam int NG   = (OUT_DIM + LANES - 1) / LANES;
   localparam int GW   = NG > 1 ? $clog2(NG) : 1;
   localparam int LW   = LANES > 1 ? $clog2(LANES) : 1;
   localparam int ACCW = acc_width(DATA_WIDTH, IN_DIM);
   dense_state_t state_q, state_d;
   logic [AW-1:0] i_q, i_d, tag_i;
   logic [GW-1:0] g_q, g_d;
   logic [LW-1:0] l_q, l_d;
   logic tag_v, drain_done, last_l, hs;
   logic signed [DATA_WIDTH-1:0] y [LANES];
   int o_emit;
   always_ff @(posedge clk)
      state_q <= reset ? IDLE : state_d;
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = LOAD;
         LOAD:    state_d = FEED;
         FEED:    if (i_q == AW'(IN_DIM - 1)) state_d = LAT == 0 ? EMIT : DRAIN;
         DRAIN:   if (drain_done) state_d = EMIT;
         EMIT:    if (hs && last_l) state_d = g_q == GW'(NG - 1) ? FINISH : LOAD;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_comb begin
      busy      = state_q != IDLE;
      in_en     = state_q == FEED;
      out_valid = state_q == EMIT;
      done      = state_q == FINISH;
      in_addr   = i_q;
      out_data  = y[l_q];
      out_idx   = OW'(o_emit);
   end
   always_comb begin
      hs     = out_valid && out_ready;
      o_emit = int'(g_q) * LANES + int'(l_q);
      last_l = l_q == LW'(LANES - 1) || o_emit == OUT_DIM - 1;
      i_d    = state_q == LOAD ? '0 : state_q == FEED ? i_q + 1'b1 : i_q;
      l_d    = state_q == LOAD ? '0 : hs ? l_q + 1'b1 : l_q;
      g_d    = state_q == IDLE ? '0 : (hs && last_l) ? g_q + 1'b1 : g_q;
   end
   always_ff @(posedge clk) begin
      i_q <= reset ? '0 : i_d;
      l_q <= reset ? '0 : l_d;
      g_q <= reset ? '0 : g_d;
   end
   // Each read is tagged with its index so the MAC sees (x[i], W[o,i]) together LAT cycles later.
   if (LAT == 0) begin : g_nopipe
      assign tag_v      = state_q == FEED;
      assign tag_i      = i_q;
      assign drain_done = 1'b1;
   end else begin : g_pipe
      logic [LAT-1:0] vld_q, vld_d;
      logic [AW-1:0]  idx_q [LAT];
      assign vld_d = (vld_q << 1) | LAT'(state_q == FEED);
      always_ff @(posedge clk) begin
         vld_q    <= reset ? '0 : vld_d;
         idx_q[0] <= i_q;
         for (int k = 1; k < LAT; k++) idx_q[k] <= idx_q[k-1];
      end
      assign tag_v      = vld_q[LAT-1];
      assign tag_i      = idx_q[LAT-1];
      assign drain_done = vld_d == '0;
   end
   for (genvar l = 0; l < LANES; l++) begin : g_lane
      int o;
      logic signed [DATA_WIDTH-1:0] w, b;
      always_comb begin
         o = int'(g_q) * LANES + l;
         w = o < OUT_DIM ? WEIGHTS[(o * IN_DIM + int'(tag_i)) * DATA_WIDTH +: DATA_WIDTH] : '0;
         b = o < OUT_DIM ? BIASES[o * DATA_WIDTH +: DATA_WIDTH] : '0;
      end
      dense_lane_mac #(.DW(DATA_WIDTH), .FRAC(FRAC_BITS), .ACCW(ACCW),
                       .SH(FRAC_BITS + POST_SHIFT), .ROUND(ROUND)) u_mac (
         .clk(clk), .reset(reset), .load_i(state_q == LOAD), .mac_i(tag_v),
         .bias_i(b), .x_i(in_q), .w_i(w), .y_o(y[l]));
   end
endmodule

// File: tb/tb_dense_lanes.sv
// tb_dense_lanes: randomized passes checked against an arithmetic model of the layer.
module tb_dense_lanes;
   localparam int IN = 4, OUT = 3, LN = 2, LAT = 2, FRAC = 7, NG = (OUT + LN - 1) / LN;
   localparam logic [OUT*IN*16-1:0] WTS = {16'hFC18, 16'h00C8, 16'hFFFB, 16'h0003,
                                          {4{16'h8000}}, {4{16'h0080}}};
   localparam logic [OUT*16-1:0] BIAS = {16'hFF00, 16'h0000, 16'h0000};
`ifdef DENSE_RELU_EN
   localparam bit RELU = 1;
`else
   localparam bit RELU = 0;
`endif
   logic clk = 0, reset = 1, start = 0, out_ready = 0;
   logic busy, in_en, out_valid, done;
   logic [1:0] in_addr, out_idx;
   logic [15:0] in_q, out_data;
   logic [15:0] xv [IN];
   logic [15:0] pipe [LAT];
   int n_chk = 0, n_fail = 0, exp_idx = 0, en_cnt = 0, done_cnt = 0, stall_left = 0;
   logic held = 0;
   logic [15:0] h_data;
   logic [1:0]  h_idx;
   longint got [OUT];
   always #5 clk = ~clk;
   dense_lanes #(.DATA_WIDTH(16), .FRAC_BITS(FRAC), .IN_DIM(IN), .OUT_DIM(OUT), .LANES(LN),
                 .LAT(LAT), .POST_SHIFT(0), .ROUND(1), .WEIGHTS(WTS), .BIASES(BIAS)) dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .in_addr(in_addr), .in_en(in_en),
      .in_q(in_q), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_idx(out_idx), .done(done));
   // Input memory with LAT-cycle read latency; junk is returned for non-read cycles.
   always @(posedge clk) begin
      pipe[0] <= in_en ? xv[in_addr] : 16'($urandom);
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
   end
   assign in_q = pipe[LAT-1];
   task automatic chk(input string nm, input longint act, input longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask
   function automatic longint model(input int o);
      longint acc;
      acc = longint'($signed(BIAS[o*16 +: 16])) * (longint'(1) << FRAC);
      for (int i = 0; i < IN; i++)
         acc += longint'($signed(xv[i])) * longint'($signed(WTS[(o*IN+i)*16 +: 16]));
      acc = (acc + (longint'(1) << (FRAC - 1))) >>> FRAC;
      if (acc > 32767) acc = 32767;
      if (acc < -32768) acc = -32768;
      if (RELU && acc < 0) acc = 0;
      return acc;
   endfunction
   always @(negedge clk) begin
      if (in_en) en_cnt++;
      if (done) done_cnt++;
      if (held) begin
         chk("hold_valid", out_valid, 1);
         chk("hold_data", out_data, h_data);
         chk("hold_idx", out_idx, h_idx);
      end
      if (out_valid && out_ready) begin
         chk("out_idx", out_idx, exp_idx);
         chk("out_data", $signed(out_data), model(exp_idx));
         if (exp_idx < OUT) got[exp_idx] = $signed(out_data);
         exp_idx++;
      end
      held = out_valid && !out_ready;
      h_data = out_data;
      h_idx = out_idx;
   end
   task automatic pulse_start();
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 start = 0;
   endtask
   task automatic run_pass(input bit stall, input bit noise);
      int cyc, d0;
      exp_idx = 0; en_cnt = 0; d0 = done_cnt; cyc = 0;
      stall_left = stall ? 5 : 0;
      pulse_start();
      chk("busy_on", busy, 1);
      forever begin
         if (stall_left > 0 && out_valid) begin
            out_ready = 0;
            stall_left--;
         end else out_ready = stall ? 1'b1 : 1'($urandom_range(0, 3) != 0);
         start = noise ? 1'($urandom_range(0, 7) == 0) : 1'b0;
         @(negedge clk); #1;
         cyc++;
         if (done_cnt != d0 || cyc >= 500) break;
         @(posedge clk); #1;
      end
      @(posedge clk); #1 start = 0;
      chk("timeout", cyc < 500, 1);
      chk("emitted", exp_idx, OUT);
      chk("in_en_cycles", en_cnt, IN * NG);
      chk("done_pulses", done_cnt - d0, 1);
      chk("busy_idle", busy, 0);
   endtask
   initial begin
      int d0;
      for (int i = 0; i < IN; i++) xv[i] = 16'd128;
      repeat (3) @(posedge clk);
      #1 reset = 0;
      chk("rst_busy", busy, 0);
      chk("rst_in_en", in_en, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_addr", in_addr, 0);
      chk("rst_idx", out_idx, 0);
      chk("rst_data", out_data, 0);
      run_pass(1, 0);
      chk("lit0_y0", got[0], 512);
      chk("lit0_y1", got[1], RELU ? 0 : -32768);
      chk("lit0_y2", got[2], RELU ? 0 : -1058);
      for (int i = 0; i < IN; i++) xv[i] = 16'h7FFF;
      run_pass(0, 1);
      chk("lit1_y0", got[0], 32767);
      chk("lit1_y1", got[1], RELU ? 0 : -32768);
      chk("lit1_y2", got[2], RELU ? 0 : -32768);
      for (int i = 0; i < IN; i++) xv[i] = 16'hFFFF;
      run_pass(0, 0);
      chk("lit2_y0", got[0], RELU ? 0 : -4);
      chk("lit2_y1", got[1], 1024);
      chk("lit2_y2", got[2], RELU ? 0 : -250);
      for (int i = 0; i < IN; i++) xv[i] = i == 2 ? 16'd1 : 16'd0;
      run_pass(0, 1);
      chk("lit3_y0", got[0], 1);
      chk("lit3_y1", got[1], RELU ? 0 : -256);
      chk("lit3_y2", got[2], RELU ? 0 : -254);
      pulse_start();
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("mid_feed_en", in_en, 1);
      reset = 1;
      @(posedge clk); #1 reset = 0;
      held = 0;
      d0 = done_cnt;
      chk("abort_busy", busy, 0);
      chk("abort_en", in_en, 0);
      chk("abort_valid", out_valid, 0);
      repeat (10) @(posedge clk);
      #1 chk("abort_no_done", done_cnt - d0, 0);
      for (int i = 0; i < IN; i++) xv[i] = 16'd128;
      run_pass(0, 0);
      chk("post_rst_y0", got[0], 512);
      for (int p = 0; p < 12; p++) begin
         for (int i = 0; i < IN; i++)
            xv[i] = p[0] ? 16'($urandom) : 16'($urandom_range(0, 511) - 256);
         run_pass(p == 5, 1);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
